// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and the
// request legality check applied at accept time.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  // Returns 1 when the request must be rejected without touching memory.
  function automatic logic req_is_bad(input logic        we,
                                      input logic [2:0]  funct3,
                                      input logic [31:0] addr,
                                      input logic [31:0] mem_bytes);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr[0];
      F3_W:    bad = (addr[1:0] != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | addr[0];
      default: bad = 1'b1;
    endcase
    if (addr >= mem_bytes) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// slave = the LSU itself; master = execute stage plus memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Big-endian lane logic shared by the load-extract and store-merge paths.
// Byte offset k lives in word bits [31-8k -: 8].
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);

  logic [4:0]  byte_hi;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_hi  = {~offset, 3'b111};
  assign byte_sel = word[byte_hi -: 8];
  assign half_sel = offset[1] ? word[15:0] : word[31:16];

  always_comb begin
    load_ext = 32'd0;
    case (funct3)
      F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_ext = word;
      F3_BU:   load_ext = {24'd0, byte_sel};
      F3_HU:   load_ext = {16'd0, half_sel};
      default: load_ext = 32'd0;
    endcase
  end

  // Each lane independently decides whether it takes new store data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       en;
      logic [7:0] nb;

      always_comb begin
        en = 1'b0;
        nb = wdata[7:0];
        case (funct3[1:0])
          2'd0: en = (offset == LANE);
          2'd1: begin
            en = (offset[1] == LANE[1]);
            nb = LANE[0] ? wdata[7:0] : wdata[15:8];
          end
          default: begin
            en = 1'b1;
            nb = wdata[31-8*gi -: 8];
          end
        endcase
      end

      assign merged[31-8*gi -: 8] = en ? nb : word[31-8*gi -: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a big-endian byte-array data memory.
// Word-aligned accesses, read-modify-write for SB/SH, registered responses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic              CLK,
  input  logic              RST,
  load_store_unit_if.slave  bus
);

  lsu_state_e  state_reg;
  logic        ready_reg;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rbuf_reg;
  logic        resp_valid_reg;
  logic        resp_err_reg;
  logic [31:0] resp_rdata_reg;
  logic        mem_read_reg;
  logic        mem_write_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;

  logic        req_bad;
  logic [31:0] align_word;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign req_bad = req_is_bad(bus.req_we, bus.req_funct3, bus.req_addr, 32'(MEM_BYTES));

  // Extract and merge both complete on the edge that ends RD, so the live read
  // data is the word that lands in rbuf on that same edge.
  assign align_word = (state_reg == S_RD) ? bus.mem_rdata : rbuf_reg;

  lsu_lane_align u_align (
    .funct3   (funct3_reg),
    .offset   (addr_reg[1:0]),
    .word     (align_word),
    .wdata    (wdata_reg),
    .load_ext (load_ext),
    .merged   (merged)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= S_IDLE;
      ready_reg      <= 1'b1;
      we_reg         <= 1'b0;
      funct3_reg     <= 3'd0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      rbuf_reg       <= 32'd0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'd0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= 32'd0;
      mem_wdata_reg  <= 32'd0;
    end else begin
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'd0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_reg     <= bus.req_we;
            funct3_reg <= bus.req_funct3;
            addr_reg   <= bus.req_addr;
            wdata_reg  <= bus.req_wdata;
            ready_reg  <= 1'b0;
            if (req_bad) begin
              state_reg      <= S_RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
            end else if (bus.req_we && bus.req_funct3 == F3_W) begin
              state_reg     <= S_WR;
              mem_write_reg <= 1'b1;
              mem_addr_reg  <= {bus.req_addr[31:2], 2'b00};
              mem_wdata_reg <= bus.req_wdata;
            end else begin
              state_reg    <= S_RD;
              mem_read_reg <= 1'b1;
              mem_addr_reg <= {bus.req_addr[31:2], 2'b00};
            end
          end
        end
        S_RD: begin
          rbuf_reg <= bus.mem_rdata;
          if (we_reg) begin
            state_reg     <= S_WR;
            mem_write_reg <= 1'b1;
            mem_addr_reg  <= {addr_reg[31:2], 2'b00};
            mem_wdata_reg <= merged;
          end else begin
            state_reg      <= S_RESP;
            resp_valid_reg <= 1'b1;
            resp_rdata_reg <= load_ext;
          end
        end
        S_WR: begin
          state_reg      <= S_RESP;
          resp_valid_reg <= 1'b1;
        end
        S_RESP: begin
          state_reg <= S_IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.mem_read   = mem_read_reg;
  // A write cycle that coincides with reset must not reach memory.
  assign bus.mem_write  = mem_write_reg & ~RST;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random requests
// against a byte-array reference model of the memory and the request rules.
module tb_load_store_unit;

  logic CLK = 1'b0;
  logic RST;
  logic fill_mem;

  always #5 CLK = ~CLK;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(512)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [7:0] mem     [512];
  logic [7:0] ref_mem [512];
  logic [8:0] mem_base;

  int n_checks = 0;
  int n_pass   = 0;

  assign mem_base = {bus.mem_addr[8:2], 2'b00};
  assign bus.mem_rdata = {mem[mem_base], mem[mem_base + 9'd1],
                          mem[mem_base + 9'd2], mem[mem_base + 9'd3]};

  always @(posedge CLK) begin
    if (fill_mem) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i * 37 + 5);
    end else if (bus.mem_write) begin
      for (int i = 0; i < 4; i++) mem[mem_base + 9'(i)] <= bus.mem_wdata[31-8*i -: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  // Reference model: request rules applied with plain byte arithmetic.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                       output int lat, output int nrd, output int nwr);
    int size;
    int a;
    err   = 1'b0;
    rdata = 32'd0;
    size  = 1 << f3[1:0];
    if (f3 == 3 || f3 == 6 || f3 == 7) err = 1'b1;
    if (we && f3 >= 4) err = 1'b1;
    if (size == 2 && addr % 2 != 0) err = 1'b1;
    if (size == 4 && addr % 4 != 0) err = 1'b1;
    if (addr >= 512) err = 1'b1;
    if (err) begin
      lat = 1; nrd = 0; nwr = 0;
      return;
    end
    a = int'(addr);
    if (!we) begin
      for (int i = 0; i < size; i++) rdata = (rdata << 8) | 32'(ref_mem[a+i]);
      if (f3 == 0 && rdata[7])  rdata = rdata | 32'hFFFF_FF00;
      if (f3 == 1 && rdata[15]) rdata = rdata | 32'hFFFF_0000;
      lat = 2; nrd = 1; nwr = 0;
    end else begin
      for (int i = 0; i < size; i++) ref_mem[a+i] = 8'(wdata >> (8 * (size - 1 - i)));
      lat = (size == 4) ? 2 : 3;
      nrd = (size == 4) ? 0 : 1;
      nwr = 1;
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge, unit idle again.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat, exp_rd, exp_wr;
    int          got_lat, got_rd, got_wr;
    logic        got_err;
    logic [31:0] got_rdata;
    model(we, f3, addr, wdata, exp_err, exp_rdata, exp_lat, exp_rd, exp_wr);
    check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
    got_lat = 0; got_rd = 0; got_wr = 0;
    got_err = 1'bx; got_rdata = 32'hx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      got_rd += int'(bus.mem_read);
      got_wr += int'(bus.mem_write);
      if (bus.resp_valid) begin
        got_lat   = c;
        got_err   = bus.resp_err;
        got_rdata = bus.resp_rdata;
        break;
      end
    end
    check({tag, " latency"}, 32'(got_lat), 32'(exp_lat));
    check({tag, " err"}, 32'(got_err), 32'(exp_err));
    check({tag, " rdata"}, got_rdata, exp_rdata);
    check({tag, " reads"}, 32'(got_rd), 32'(exp_rd));
    check({tag, " writes"}, 32'(got_wr), 32'(exp_wr));
    @(negedge CLK);
    check({tag, " pulse"}, {bus.resp_valid, bus.resp_err, bus.resp_rdata[29:0]}, 32'd0);
    $display("txn %s we=%0d f3=%0d addr=%h wdata=%h -> lat=%0d err=%0d rdata=%h",
             tag, we, f3, addr, wdata, got_lat, got_err, got_rdata);
  endtask

  initial begin
    int          rsv;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic        we;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'(i * 37 + 5);

    RST = 1'b1;
    fill_mem = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    fill_mem = 1'b0;
    #1;
    check("rst ready", 32'(bus.req_ready), 32'd1);
    check("rst resp", {bus.resp_valid, bus.resp_err, 30'd0}, 32'd0);
    check("rst rdata", bus.resp_rdata, 32'd0);
    check("rst strobes", {bus.mem_read, bus.mem_write, 30'd0}, 32'd0);
    check("rst mem_addr", bus.mem_addr, 32'd0);
    check("rst mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge CLK);

    do_req("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    check("sw10 mem", mem_word(16), 32'hDEADBEEF);
    do_req("lw10", 1'b0, 3'd2, 32'h10, 32'h0);
    do_req("sb11", 1'b1, 3'd0, 32'h11, 32'h12345677);
    check("sb11 mem", mem_word(16), 32'hDE77BEEF);
    do_req("lb11", 1'b0, 3'd0, 32'h11, 32'h0);
    do_req("lb10", 1'b0, 3'd0, 32'h10, 32'h0);
    do_req("lbu10", 1'b0, 3'd4, 32'h10, 32'h0);
    do_req("sh12", 1'b1, 3'd1, 32'h12, 32'hAAAA8001);
    check("sh12 mem", mem_word(16), 32'hDE778001);
    do_req("lh12", 1'b0, 3'd1, 32'h12, 32'h0);
    do_req("lhu12", 1'b0, 3'd5, 32'h12, 32'h0);
    do_req("err lw13", 1'b0, 3'd2, 32'h13, 32'h0);
    do_req("err lh11", 1'b0, 3'd1, 32'h11, 32'h0);
    do_req("err sw200", 1'b1, 3'd2, 32'h200, 32'h11223344);
    do_req("err f3_3", 1'b0, 3'd3, 32'h0, 32'h0);
    do_req("err sbu", 1'b1, 3'd4, 32'h4, 32'h0);
    do_req("lb1ff", 1'b0, 3'd0, 32'h1FF, 32'h0);

    // Reset landing on the write cycle of a read-modify-write.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h55;
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
    @(negedge CLK);
    check("rstwr rd strobe", 32'(bus.mem_read), 32'd1);
    @(negedge CLK);
    check("rstwr wr strobe", 32'(bus.mem_write), 32'd1);
    RST = 1'b1;
    #1 check("rstwr gated", 32'(bus.mem_write), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    check("rstwr ready", 32'(bus.req_ready), 32'd1);
    check("rstwr mem", mem_word(16), 32'hDE778001);
    rsv = 0;
    for (int c = 0; c < 3; c++) begin
      rsv += int'(bus.resp_valid);
      @(negedge CLK);
    end
    check("rstwr no resp", 32'(rsv), 32'd0);
    $display("txn rstwr sb addr=00000010 dropped by reset");

    for (int n = 0; n < 200; n++) begin
      rsv = int'($urandom_range(0, 19));
      case ($urandom_range(0, 4))
        0: f3 = 3'd0;
        1: f3 = 3'd1;
        2: f3 = 3'd2;
        3: f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
      if (rsv == 0) f3 = 3'(6 + $urandom_range(0, 1));
      if (rsv == 1) f3 = 3'd3;
      we = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      if (rsv == 2) addr = 32'd512 + $urandom_range(0, 1000);
      if (rsv == 3) addr = $urandom;
      do_req($sformatf("rnd%0d", n), we, f3, addr, $urandom);
    end

    for (int w = 0; w < 128; w++)
      check($sformatf("final word %0d", w), mem_word(w * 4),
            {ref_mem[w*4], ref_mem[w*4+1], ref_mem[w*4+2], ref_mem[w*4+3]});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
